// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract.
// Truncating (no rounding), denormal-aware, valid/ready on both sides.
module fp_addsub_seq #(
  parameter int unsigned BYPASS_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CHECK, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [7:0] BYPASS = 8'(BYPASS_SHIFT);

  state_t      state;
  logic [31:0] a_r, b_r;
  logic        sign_l, sign_s;
  logic [8:0]  exp_r;
  logic [24:0] mant_l, mant_s, m;
  logic [4:0]  shift_cnt;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_larger;
  logic [31:0] l_op, s_op;
  logic [7:0]  l_exp, s_exp, diff;
  logic [24:0] l_mant, s_mant;
  logic        special_hit;
  logic [31:0] special_res;

  // Classify captured operands, order by magnitude and resolve special cases
  always_comb begin
    a_nan    = (a_r[30:23] == 8'hFF) && (a_r[22:0] != '0);
    b_nan    = (b_r[30:23] == 8'hFF) && (b_r[22:0] != '0);
    a_inf    = (a_r[30:23] == 8'hFF) && (a_r[22:0] == '0);
    b_inf    = (b_r[30:23] == 8'hFF) && (b_r[22:0] == '0);
    a_zero   = (a_r[30:0] == '0);
    b_zero   = (b_r[30:0] == '0);
    a_larger = (a_r[30:0] >= b_r[30:0]);
    l_op     = a_larger ? a_r : b_r;
    s_op     = a_larger ? b_r : a_r;
    l_exp    = (l_op[30:23] == 8'h00) ? 8'd1 : l_op[30:23];
    s_exp    = (s_op[30:23] == 8'h00) ? 8'd1 : s_op[30:23];
    diff     = l_exp - s_exp;
    l_mant   = {1'b0, (l_op[30:23] != 8'h00), l_op[22:0]};
    s_mant   = {1'b0, (s_op[30:23] != 8'h00), s_op[22:0]};

    special_hit = 1'b1;
    special_res = '0;
    if (a_nan)                special_res = a_r;
    else if (b_nan)           special_res = b_r;
    else if (a_inf && b_inf)  special_res = (a_r[31] == b_r[31]) ? a_r : 32'h7FC00000;
    else if (a_inf)           special_res = a_r;
    else if (b_inf)           special_res = b_r;
    else if (a_zero)          special_res = b_r;
    else if (b_zero)          special_res = a_r;
    else                      special_hit = 1'b0;
  end

  // Control FSM and datapath with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      exp_r     <= '0;
      mant_l    <= '0;
      mant_s    <= '0;
      m         <= '0;
      shift_cnt <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= {b[31] ^ op_sub, b[30:0]};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (special_hit) begin
            result    <= special_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (diff >= BYPASS) begin
            result    <= l_op;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sign_l    <= l_op[31];
            sign_s    <= s_op[31];
            exp_r     <= {1'b0, l_exp};
            mant_l    <= l_mant;
            mant_s    <= s_mant;
            shift_cnt <= diff[4:0];
            state     <= (diff != 8'd0) ? ALIGN : ADD;
          end
        end
        ALIGN: begin
          mant_s    <= mant_s >> 1;
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) state <= ADD;
        end
        ADD: begin
          m     <= (sign_l == sign_s) ? (mant_l + mant_s) : (mant_l - mant_s);
          state <= NORM;
        end
        NORM: begin
          if (m == '0) begin
            result    <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (m[24]) begin
            m     <= m >> 1;
            exp_r <= exp_r + 9'd1;
            if (exp_r == 9'd254) begin
              result    <= {sign_l, 8'hFF, 23'h0};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (!m[23] && (exp_r > 9'd1)) begin
            m     <= m << 1;
            exp_r <= exp_r - 9'd1;
          end else begin
            result    <= {sign_l, (m[23] ? exp_r[7:0] : 8'h00), m[22:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed and randomized checks of fp_addsub_seq against
// an arithmetic reference model (value and out_valid timing).
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  bit          tracking = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  fp_addsub_seq #(.BYPASS_SHIFT(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  // Reference: value and the edge index (accept = 0) at which the result is taken
  function automatic void model(input logic [31:0] ai, input logic [31:0] bi, input logic op,
                                output logic [31:0] res, output int lat);
    logic [31:0] x, y, l, s;
    logic [63:0] ml, ms, mm;
    int el, es, d, e, p, sh, nc;
    x = ai;
    y = {bi[31] ^ op, bi[30:0]};
    lat = 2;
    res = '0;
    if (is_nan(x))                  res = x;
    else if (is_nan(y))             res = y;
    else if (is_inf(x) && is_inf(y)) res = (x[31] == y[31]) ? x : 32'h7FC00000;
    else if (is_inf(x))             res = x;
    else if (is_inf(y))             res = y;
    else if (x[30:0] == 31'h0)      res = y;
    else if (y[30:0] == 31'h0)      res = x;
    else begin
      if (x[30:0] >= y[30:0]) begin l = x; s = y; end
      else begin l = y; s = x; end
      el = (l[30:23] == 8'h00) ? 1 : int'(l[30:23]);
      es = (s[30:23] == 8'h00) ? 1 : int'(s[30:23]);
      d = el - es;
      if (d >= 24) res = l;
      else begin
        ml = ((l[30:23] != 8'h00) ? 64'h800000 : 64'h0) + 64'(l[22:0]);
        ms = (((s[30:23] != 8'h00) ? 64'h800000 : 64'h0) + 64'(s[22:0])) >> d;
        mm = (l[31] == s[31]) ? ml + ms : ml - ms;
        e = el;
        nc = 1;
        if (mm == 64'h0) res = '0;
        else begin
          p = 0;
          for (int i = 0; i < 25; i++) if (mm[i]) p = i;
          if (p == 24) begin
            mm = mm >> 1;
            e = e + 1;
            if (e == 255) res = {l[31], 8'hFF, 23'h0};
            else begin
              res = {l[31], 8'(e), mm[22:0]};
              nc = 2;
            end
          end else begin
            sh = 23 - p;
            if (sh > e - 1) sh = e - 1;
            mm = mm << sh;
            e = e - sh;
            nc = sh + 1;
            res = {l[31], (mm[23] ? 8'(e) : 8'h00), mm[22:0]};
          end
        end
        lat = 3 + d + nc;
      end
    end
  endfunction

  // Per-cycle comparison of all outputs against the model's expected timeline
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", result, 32'h0);
    end else if (tracking) begin
      cyc++;
      check("busy_in_ready", 32'(in_ready), 32'd0);
      check("busy_busy", 32'(busy), 32'd1);
      if (cyc < exp_lat) begin
        check("early_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_valid", 32'(out_valid), 32'd1);
        check("result", result, exp_res);
      end
    end else begin
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                        input bit pin, input logic [31:0] want, input int want_lat,
                        input int hold, input bit poke);
    logic [31:0] mres;
    int          mlat;
    model(ta, tb, top, mres, mlat);
    if (pin) begin
      check("model_result", mres, want);
      check("model_latency", 32'(mlat), 32'(want_lat));
    end
    @(posedge clk); #1;
    a = ta; b = tb; op_sub = top; in_valid = 1'b1;
    exp_res = mres; exp_lat = mlat;
    @(posedge clk); #1;
    in_valid = 1'b0; cyc = 0; tracking = 1'b1;
    while (cyc < exp_lat) begin
      @(posedge clk); #1;
      if (poke) begin
        in_valid = 1'b1; a = $urandom; b = $urandom; op_sub = 1'($urandom);
      end
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tracking = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp(input logic [7:0] base);
    logic [31:0] r;
    int unsigned mode;
    r = $urandom;
    mode = $urandom_range(0, 11);
    case (mode)
      0: r[30:0] = 31'h0;
      1: begin
        r[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) r[22:0] = 23'h0;
      end
      2: r[30:23] = 8'h00;
      3: r[30:23] = 8'hFE;
      default: r[30:23] = base + 8'($urandom_range(0, 30));
    endcase
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, completed %0d of required checks", n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  base;
    vecs[0]  = '{32'h0480000F, 32'h00000000, 1'b0, 32'h0480000F, 2};
    vecs[1]  = '{32'h3F800000, 32'h7F80000F, 1'b0, 32'h7F80000F, 2};
    vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 2};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2};
    vecs[4]  = '{32'h04800001, 32'h04800001, 1'b0, 32'h05000001, 5};
    vecs[5]  = '{32'h04FFFFFF, 32'h04800001, 1'b0, 32'h05400000, 5};
    vecs[6]  = '{32'h04800003, 32'h84800001, 1'b0, 32'h00000200, 12};
    vecs[7]  = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 4};
    vecs[8]  = '{32'h03000000, 32'h82000000, 1'b0, 32'h02C00000, 7};
    vecs[9]  = '{32'h03000000, 32'h02000000, 1'b1, 32'h02C00000, 7};
    vecs[10] = '{32'h107FFFFF, 32'h02000001, 1'b0, 32'h107FFFFF, 2};
    vecs[11] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, vecs[i].res, vecs[i].lat,
             (i == 5) ? 10 : 0, (i == 8));

    // Abort an operation while it is aligning; nothing may be emitted
    @(posedge clk); #1;
    a = 32'h0A000000; b = 32'h05000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cyc = 0; exp_lat = 100; tracking = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    tracking = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    run_op(32'h03000000, 32'h82000000, 1'b0, 1'b1, 32'h02C00000, 7, 0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      base = 8'($urandom_range(0, 230));
      ra = rand_fp(base);
      rb = ($urandom_range(0, 15) == 0) ? ra : rand_fp(base);
      run_op(ra, rb, 1'($urandom), 1'b0, 32'h0, 0,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Multi-cycle IEEE-754 single-precision add/subtract unit with valid/ready handshakes on both operand and result sides. It is the sequential counterpart of the combinational FP ALU add path and produces bit-identical results: truncation, no rounding, and denormals supported. It sits between the FP register-file read stage and FP writeback for F-extension FADD.S/FSUB.S. Variable latency lets the core stall on in_ready/out_valid.

## Interface
- BYPASS_SHIFT, 24: exponent difference at or above which the smaller operand is ignored and the larger is returned unchanged.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- op_sub  input  1  0 = a+b, 1 = a−b (b sign inverted at capture).
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer takes result.
- result  output  32  registered result, held stable while out_valid.
- busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE, CHECK, ALIGN, ADD, NORM, DONE.
- **IDLE**
  - in_valid & in_ready: capture a, b and op_sub, with b sign = b[31]^op_sub. Go to CHECK.
- **CHECK** (1 cycle), special cases in this priority, each writing result and going to DONE:
  - a NaN (exp=255, mant≠0): result = a.
  - Else b NaN: result = b after sign fix.
  - a and b both ∞ with the same sign: result = a.
  - a and b both ∞ with opposite signs: result = 32'h7FC00000.
  - a ∞: result = a. b ∞: result = b.
  - a = ±0: result = b. b = ±0: result = a.
- **CHECK, normal path**
  - Unpack: exp=0 → effective exp 1, hidden bit 0; otherwise hidden bit 1.
  - Order by {exp,mant} magnitude so that L is the larger operand and S the smaller. Compute d = expL − expS.
  - d ≥ BYPASS_SHIFT: result = L, go to DONE.
  - Otherwise go to ALIGN if d > 0, else to ADD.
- **ALIGN**
  - Shift S's 25-bit mantissa {carry, hidden, 23} right by 1 per cycle, discarding the LSB. Decrement d.
  - Go to ADD when d reaches 0.
- **ADD** (1 cycle)
  - Same signs: M = L+S. Different signs: M = L−S.
  - Result sign = sign of L. Go to NORM.
- **NORM**, one action per cycle, evaluated in this order:
  - M = 0: result = +0, go to DONE.
  - Carry bit set: shift M right 1 and exp+1. If exp reaches 255, result = ±∞ with the sign of L, go to DONE.
  - Hidden bit clear and exp > 1: shift M left 1 and exp−1.
  - Otherwise pack and go to DONE. Exp field = 0 if the hidden bit is 0 (denormal), else exp.
- **DONE**
  - out_valid = 1, result held.
  - out_ready: go to IDLE. in_ready goes high the next cycle; there is no same-cycle re-accept.

## Timing
- Reset values: state IDLE, result 0, out_valid 0, busy 0, in_ready 1.
- Accept edge = cycle 0.
- Special-case or bypass results: out_valid at cycle 2.
- Normal path: out_valid at cycle 4+d+k, where k = number of NORM shift steps.
- Throughput: one operation in flight. A new accept is possible at the earliest one cycle after the out_valid & out_ready edge.
- out_valid is held indefinitely under backpressure (out_ready low). result and out_valid do not change until the handshake completes.
- in_valid while busy is ignored; the source must hold its operands.
- rst_n asserted mid-operation aborts immediately: outputs return to reset values and no result is emitted.
- Arithmetic widths:
  - Mantissa datapath: 25 bits.
  - Exponent register: 9 bits, for the overflow check.
  - Shift counter: 5 bits.

## Test plan
- **Add zero, NaN, ∞**
  - a=0x0480000F, b=0 → result 0x0480000F at cycle 2.
  - b=0x7F80000F → result = b.
  - a=b=0x7F800000 → 0x7F800000.
  - a=0x7F800000, op_sub=1, b=0x7F800000 → 0x7FC00000.
- **Equal-exponent add**
  - a=0x04800001, b=0x04800001 → 0x05000001 at cycle 5 (d=0, k=1).
  - a=0x04FFFFFF, b=0x04800001 → 0x05400000.
- **Cancellation to denormal**
  - a=0x04800003, b=0x84800001 → 0x00000200, with NORM stopping at exp 1.
  - a=b → +0.
- **Aligned subtract**
  - a=0x03000000, b=0x82000000 → 0x02C00000 (d=2, k=1, out_valid at cycle 7).
  - Same operands with op_sub=1 and b=0x02000000 → identical result.
- **Bypass and overflow**
  - a=0x107FFFFF, b=0x02000001 (d=28) → a at cycle 2.
  - a=b=0x7F7FFFFF → 0x7F800000.
- **Handshake and reset**
  - Hold out_ready low 10 cycles → result stable, in_ready low throughout.
  - in_valid pulses while busy → ignored.
  - rst_n low during ALIGN → out_valid never asserts. The next operation after release is correct.
